gpr_regfile: RTL and testbench
==============================

Name: gpr_regfile

Overview:
Architectural integer register file for the NPC core. Takes the write-back stream from the pipeline and serves two combinational operand reads. Drives the flattened gpr_0..gpr_31 buses that feed the DPI-C register export for difftest. Adds a handshaked dump engine that streams all 32 registers, one per beat, to the simulator-side checker on request.

Parameters:
XLEN, 64, register width in bits
NREG, 32, number of architectural registers (fixed at 32)
AW, 5, register index width, equal to log2(NREG)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
wen  input  1  write-back enable
waddr  input  AW  write-back register index
wdata  input  XLEN  write-back data
raddr1  input  AW  read port 1 index
rdata1  output  XLEN  read port 1 data, combinational
raddr2  input  AW  read port 2 index
rdata2  output  XLEN  read port 2 data, combinational
dump_req  input  1  single-cycle request to start a register dump
dump_valid  output  1  dump beat valid
dump_ready  input  1  checker accepts the beat
dump_idx  output  AW  index of the current beat
dump_data  output  XLEN  value of the current beat, registered
dump_busy  output  1  high in states STREAM and DONE
dump_done  output  1  one-cycle pulse after the last beat is accepted
gpr_0..gpr_31  output  XLEN each  live register contents, for difftest export

Behaviour:
- Reset (rst=0, asynchronous): all 32 registers clear to 0.
  - State goes to IDLE.
  - dump_valid=0, dump_idx=0, dump_data=0, dump_busy=0, dump_done=0.
- x0:
  - A write to index 0 is discarded.
  - gpr_0 is always 0.
  - A read of index 0 returns 0, including under bypass.
- Write: when wen=1 and waddr!=0, rf[waddr] is set to wdata at the clock edge.
  - gpr_N shows the new value from the next cycle.
- Read: rdataK = 0 if raddrK=0.
  - Else wdata if wen and waddr==raddrK (same-cycle bypass).
  - Else rf[raddrK].
  - Both ports are independent and may alias each other.
- Dump FSM, states IDLE, STREAM, DONE:
  - IDLE: dump_req=1 moves to STREAM.
    - dump_idx is set to 0.
    - dump_data is loaded with the bypassed value of rf[0] (= 0).
    - dump_valid is set to 1.
  - STREAM: dump_valid=1 throughout.
    - dump_idx and dump_data stay stable until dump_ready=1.
    - A handshake (valid & ready) with dump_idx<31 increments dump_idx.
    - On that handshake, dump_data is loaded with the value of rf[idx+1], bypassed against the same-cycle write.
    - A later write to an index whose beat is already loaded does not change dump_data.
  - STREAM exit: a handshake with dump_idx=31 moves to DONE.
    - dump_valid drops to 0.
  - DONE: lasts exactly one cycle.
    - dump_done=1 in that cycle, then return to IDLE.
- dump_req outside IDLE is ignored; it is not queued.
- Throughput: one beat per cycle when dump_ready stays high.
  - A full dump takes 1 cycle to enter STREAM, then 32 beats, then 1 DONE cycle.
- Writes are never stalled by a dump. The core may use dump_busy to freeze retirement if it needs a consistent snapshot.
- Reset asserted mid-dump aborts the dump immediately. No dump_done pulse is produced.

Decomposition:
- Shared package npc_pkg:
  - XLEN and REG_AW constants.
  - dump state enum: IDLE, STREAM, DONE.
- One sub-module, gpr_dump_fsm.
  - Holds the state, index counter and handshake.
  - Gets the bypassed read value through a third internal read mux that lives in gpr_regfile.
- The storage array and the read/bypass muxes stay in gpr_regfile.

Test Plan:
- Reset, then write x5=0x1122334455667788 -> the next cycle gpr_5 and rdata1 (raddr1=5) both show that value; all other gpr_N stay 0.
- Write x0=0xFFFF -> gpr_0=0, rdata2 (raddr2=0)=0, including in the write cycle itself.
- Same-cycle write x7=0xABCD with raddr1=raddr2=7 -> rdata1=rdata2=0xABCD in that cycle; gpr_7=0xABCD the cycle after.
- Preload xN=N*0x10, then dump with dump_ready held at 1 -> 32 consecutive beats with idx 0..31 and data N*0x10, x0 giving 0; dump_done pulses on the cycle after beat 31.
- Dump with dump_ready toggled 1/0 and a write x3=0x99 issued while beat 3 is held -> beat 3 keeps its old value while held; dump_req pulses during STREAM start no second dump.
- Assert rst=0 at beat 10 -> dump_valid and dump_busy drop asynchronously, no dump_done pulse; a new dump_req after reset restarts at idx 0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared NPC core constants and the register-dump state encoding.
package npc_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DONE   = 2'b10
    } dump_state_e;

endpackage

// File: rtl/gpr_dump_fsm.sv
// Dump engine: walks x0..x31 one beat per valid/ready handshake, then pulses done.
module gpr_dump_fsm
    import npc_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump_req,
    input  logic          dump_ready,
    input  logic [DW-1:0] rd_data,
    output logic [AW-1:0] rd_addr,
    output logic          dump_valid,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          dump_busy,
    output logic          dump_done
);

    localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
    localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

    dump_state_e   state_r, state_s;
    logic [AW-1:0] idx_r, idx_s;
    logic [DW-1:0] data_r, data_s;
    logic          valid_r, valid_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          hs_s;

    assign hs_s = valid_r & dump_ready;

    // The register file answers for the beat that will be loaded next (x0 when starting).
    always_comb begin
        if (state_r == STREAM) begin
            rd_addr = idx_r + IDX_ONE;
        end else begin
            rd_addr = {AW{1'b0}};
        end
    end

    // Next-state and next-output logic for the dump engine.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        data_s  = data_r;
        valid_s = valid_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (dump_req) begin
                    state_s = STREAM;
                    idx_s   = {AW{1'b0}};
                    data_s  = rd_data;
                    valid_s = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            STREAM: begin
                if (hs_s && (idx_r == LAST_IDX)) begin
                    state_s = DONE;
                    valid_s = 1'b0;
                    done_s  = 1'b1;
                end else if (hs_s) begin
                    idx_s  = idx_r + IDX_ONE;
                    data_s = rd_data;
                end else begin
                    valid_s = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Dump state and registered outputs; reset aborts any dump in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            idx_r   <= {AW{1'b0}};
            data_r  <= {DW{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign dump_valid = valid_r;
    assign dump_idx   = idx_r;
    assign dump_data  = data_r;
    assign dump_busy  = busy_r;
    assign dump_done  = done_r;

endmodule

// File: rtl/gpr_regfile.sv
// Architectural integer register file: write-back port, two bypassed read ports,
// flattened difftest export and a handshaked dump engine.
module gpr_regfile #(
    parameter int XLEN = npc_pkg::XLEN,
    parameter int NREG = 32,
    parameter int AW   = npc_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            dump_req,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_busy,
    output logic            dump_done,
    output logic [XLEN-1:0] gpr_0,  output logic [XLEN-1:0] gpr_1,
    output logic [XLEN-1:0] gpr_2,  output logic [XLEN-1:0] gpr_3,
    output logic [XLEN-1:0] gpr_4,  output logic [XLEN-1:0] gpr_5,
    output logic [XLEN-1:0] gpr_6,  output logic [XLEN-1:0] gpr_7,
    output logic [XLEN-1:0] gpr_8,  output logic [XLEN-1:0] gpr_9,
    output logic [XLEN-1:0] gpr_10, output logic [XLEN-1:0] gpr_11,
    output logic [XLEN-1:0] gpr_12, output logic [XLEN-1:0] gpr_13,
    output logic [XLEN-1:0] gpr_14, output logic [XLEN-1:0] gpr_15,
    output logic [XLEN-1:0] gpr_16, output logic [XLEN-1:0] gpr_17,
    output logic [XLEN-1:0] gpr_18, output logic [XLEN-1:0] gpr_19,
    output logic [XLEN-1:0] gpr_20, output logic [XLEN-1:0] gpr_21,
    output logic [XLEN-1:0] gpr_22, output logic [XLEN-1:0] gpr_23,
    output logic [XLEN-1:0] gpr_24, output logic [XLEN-1:0] gpr_25,
    output logic [XLEN-1:0] gpr_26, output logic [XLEN-1:0] gpr_27,
    output logic [XLEN-1:0] gpr_28, output logic [XLEN-1:0] gpr_29,
    output logic [XLEN-1:0] gpr_30, output logic [XLEN-1:0] gpr_31
);

    logic [XLEN-1:0] rf_r [NREG];
    logic [AW-1:0]   dump_raddr_s;
    logic [XLEN-1:0] dump_rdata_s;

    // x0 reads as zero; otherwise a same-cycle write-back wins over the stored value.
    function automatic logic [XLEN-1:0] bypass_read(
        input logic [AW-1:0]   addr,
        input logic            we,
        input logic [AW-1:0]   wa,
        input logic [XLEN-1:0] wd,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] val;
        if (addr == {AW{1'b0}}) begin
            val = {XLEN{1'b0}};
        end else if (we && (wa == addr)) begin
            val = wd;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Register storage; writes to x0 are dropped so rf_r[0] stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= {XLEN{1'b0}};
            end
        end else if (wen && (waddr != {AW{1'b0}})) begin
            rf_r[waddr] <= wdata;
        end
    end

    // Operand read ports plus the internal port that feeds the dump engine.
    always_comb begin
        rdata1       = bypass_read(raddr1, wen, waddr, wdata, rf_r[raddr1]);
        rdata2       = bypass_read(raddr2, wen, waddr, wdata, rf_r[raddr2]);
        dump_rdata_s = bypass_read(dump_raddr_s, wen, waddr, wdata, rf_r[dump_raddr_s]);
    end

    gpr_dump_fsm #(
        .DW (XLEN),
        .AW (AW)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .rd_data    (dump_rdata_s),
        .rd_addr    (dump_raddr_s),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    assign gpr_0  = {XLEN{1'b0}};
    assign gpr_1  = rf_r[1];   assign gpr_2  = rf_r[2];   assign gpr_3  = rf_r[3];
    assign gpr_4  = rf_r[4];   assign gpr_5  = rf_r[5];   assign gpr_6  = rf_r[6];
    assign gpr_7  = rf_r[7];   assign gpr_8  = rf_r[8];   assign gpr_9  = rf_r[9];
    assign gpr_10 = rf_r[10];  assign gpr_11 = rf_r[11];  assign gpr_12 = rf_r[12];
    assign gpr_13 = rf_r[13];  assign gpr_14 = rf_r[14];  assign gpr_15 = rf_r[15];
    assign gpr_16 = rf_r[16];  assign gpr_17 = rf_r[17];  assign gpr_18 = rf_r[18];
    assign gpr_19 = rf_r[19];  assign gpr_20 = rf_r[20];  assign gpr_21 = rf_r[21];
    assign gpr_22 = rf_r[22];  assign gpr_23 = rf_r[23];  assign gpr_24 = rf_r[24];
    assign gpr_25 = rf_r[25];  assign gpr_26 = rf_r[26];  assign gpr_27 = rf_r[27];
    assign gpr_28 = rf_r[28];  assign gpr_29 = rf_r[29];  assign gpr_30 = rf_r[30];
    assign gpr_31 = rf_r[31];

endmodule

// File: tb/tb_gpr_regfile.sv
// Randomized self-checking bench for gpr_regfile against an array-based reference model.
module tb_gpr_regfile;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   raddr1, raddr2;
    logic [XLEN-1:0] rdata1, rdata2;
    logic            dump_req, dump_valid, dump_ready, dump_busy, dump_done;
    logic [AW-1:0]   dump_idx;
    logic [XLEN-1:0] dump_data;
    logic [XLEN-1:0] gpr [NREG];

    int n_checks = 0;
    int n_errors = 0;

    // reference model: architectural registers plus the dump as seen by the checker
    logic [XLEN-1:0] model [NREG];
    int              phase;      // 0 idle, 1 streaming, 2 done cycle
    int              e_idx;
    logic [XLEN-1:0] e_data;
    logic            e_valid, e_busy, e_done;
    int              beats;

    always #5 clk = ~clk;

    gpr_regfile dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy),
        .dump_done(dump_done),
        .gpr_0(gpr[0]),   .gpr_1(gpr[1]),   .gpr_2(gpr[2]),   .gpr_3(gpr[3]),
        .gpr_4(gpr[4]),   .gpr_5(gpr[5]),   .gpr_6(gpr[6]),   .gpr_7(gpr[7]),
        .gpr_8(gpr[8]),   .gpr_9(gpr[9]),   .gpr_10(gpr[10]), .gpr_11(gpr[11]),
        .gpr_12(gpr[12]), .gpr_13(gpr[13]), .gpr_14(gpr[14]), .gpr_15(gpr[15]),
        .gpr_16(gpr[16]), .gpr_17(gpr[17]), .gpr_18(gpr[18]), .gpr_19(gpr[19]),
        .gpr_20(gpr[20]), .gpr_21(gpr[21]), .gpr_22(gpr[22]), .gpr_23(gpr[23]),
        .gpr_24(gpr[24]), .gpr_25(gpr[25]), .gpr_26(gpr[26]), .gpr_27(gpr[27]),
        .gpr_28(gpr[28]), .gpr_29(gpr[29]), .gpr_30(gpr[30]), .gpr_31(gpr[31])
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wen && waddr == a) return wdata;
        return model[a];
    endfunction

    task automatic check_state();
        chk("dump_valid", XLEN'(dump_valid), XLEN'(e_valid));
        chk("dump_busy", XLEN'(dump_busy), XLEN'(e_busy));
        chk("dump_done", XLEN'(dump_done), XLEN'(e_done));
        if (e_valid) begin
            chk("dump_idx", XLEN'(dump_idx), XLEN'(e_idx));
            chk("dump_data", dump_data, e_data);
        end
        for (int i = 0; i < NREG; i++) chk($sformatf("gpr_%0d", i), gpr[i], model[i]);
    endtask

    // one clock: check registered state, apply inputs, check reads, advance model
    task automatic cycle(input logic w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic rq, input logic rd);
        logic hs;
        @(negedge clk);
        check_state();
        wen = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
        dump_req = rq; dump_ready = rd;
        #1;
        chk("rdata1", rdata1, exp_read(raddr1));
        chk("rdata2", rdata2, exp_read(raddr2));
        hs = e_valid && dump_ready;
        if (hs) beats++;
        if (wen && waddr != 0) model[waddr] = wdata;
        e_done = 1'b0;
        case (phase)
            0: if (dump_req) begin
                phase = 1; e_idx = 0; e_data = '0; e_valid = 1'b1; e_busy = 1'b1; beats = 0;
            end
            1: if (hs) begin
                if (e_idx == NREG - 1) begin
                    phase = 2; e_valid = 1'b0; e_done = 1'b1;
                    chk("beat_count", XLEN'(beats), XLEN'(NREG));
                end else begin
                    e_idx++;
                    e_data = model[e_idx];
                end
            end
            default: begin phase = 0; e_busy = 1'b0; end
        endcase
    endtask

    task automatic idle_cycle();
        cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", XLEN'(dump_valid), '0);
        chk("rst_busy", XLEN'(dump_busy), '0);
        chk("rst_done", XLEN'(dump_done), '0);
        chk("rst_idx", XLEN'(dump_idx), '0);
        chk("rst_data", dump_data, '0);
        for (int i = 0; i < NREG; i++) begin
            model[i] = '0;
            chk("rst_gpr", gpr[i], '0);
        end
        phase = 0; e_idx = 0; e_data = '0; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        wen = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        int k;
        rst = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
        dump_req = 1'b0; dump_ready = 1'b0;
        do_reset();

        // basic write, x0 discard, same-cycle bypass on both ports
        cycle(1'b1, 5'd5, 64'h1122334455667788, 5'd5, 5'd0, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 64'h0, 5'd5, 5'd5, 1'b0, 1'b0);
        cycle(1'b1, 5'd0, 64'hFFFF, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle(1'b1, 5'd7, 64'hABCD, 5'd7, 5'd7, 1'b0, 1'b0);
        idle_cycle();

        // preload xN = N*0x10, then a full-throughput dump
        for (int n = 1; n < NREG; n++) cycle(1'b1, AW'(n), XLEN'(n * 16), AW'(n), 5'd0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
        k = 0;
        while (phase != 0 && k < 100) begin
            cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
            k++;
        end
        chk("dump1_end", XLEN'(phase), '0);

        // throttled dump; overwrite x3 while its beat is held; extra requests ignored
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
        k = 0;
        while (phase != 0 && k < 200) begin
            logic rd;
            logic w;
            rd = (k % 2 == 0);
            w  = (e_valid && e_idx == 3 && !rd);
            cycle(w, 5'd3, 64'h99, 5'd3, '0, (k % 5 == 0), rd);
            k++;
        end
        chk("dump2_end", XLEN'(phase), '0);
        chk("x3_updated", model[3], 64'h99);

        // reset at beat 10 aborts the dump
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
        k = 0;
        while (e_idx != 10 && k < 100) begin
            cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
            k++;
        end
        chk("reached_beat10", XLEN'(e_idx), 64'd10);
        do_reset();
        idle_cycle();
        idle_cycle();
        cycle(1'b1, 5'd9, 64'h5A5A, '0, '0, 1'b1, 1'b1);
        k = 0;
        while (phase != 0 && k < 100) begin
            cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
            k++;
        end
        chk("dump3_end", XLEN'(phase), '0);

        // random traffic with concurrent dumps
        for (int c = 0; c < 1500; c++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom_range(0, NREG - 1));
            cycle(($urandom_range(0, 3) != 0), wa, {$urandom, $urandom},
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NREG - 1)),
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NREG - 1)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
